// File: rtl/pipe_hazard_pkg.sv
// Shared types for the pipeline hazard/stall sequencer: FSM states, winning-condition
// codes and the control bundle driven to the pipeline registers.
package pipe_hazard_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_LU_STALL = 2'd1,
    ST_MEM_WAIT = 2'd2,
    ST_RECOVER  = 2'd3
  } hz_state_e;

  // Which condition wins the per-cycle priority (busy > load_use > branch > normal).
  typedef enum logic [1:0] {
    WIN_NORMAL   = 2'd0,
    WIN_BRANCH   = 2'd1,
    WIN_LOAD_USE = 2'd2,
    WIN_BUSY     = 2'd3
  } hz_win_e;

  localparam int STATE_W  = 2;
  localparam int REG_ZERO = 0;
  localparam int CTRL_W   = 6;

  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic ifid_flush;
    logic idex_stall;
    logic idex_bubble;
    logic freeze;
  } hz_ctrl_t;

  localparam hz_ctrl_t CTRL_RESET  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  localparam hz_ctrl_t CTRL_BUSY   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  localparam hz_ctrl_t CTRL_LU     = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  localparam hz_ctrl_t CTRL_BRANCH = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  localparam hz_ctrl_t CTRL_NORMAL = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_cmp.sv
// Combinational load-use comparator: a load in EX whose destination is read by the
// instruction in ID. Register $0 never creates a dependence.
module hazard_cmp
  import pipe_hazard_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] id_rs_i,
  input  logic [REG_AW-1:0] id_rt_i,
  input  logic              id_uses_rt_i,
  input  logic [REG_AW-1:0] ex_rt_i,
  input  logic              ex_memread_i,
  output logic              load_use_o
);

  logic w_dst_nonzero;
  logic w_rs_hit;
  logic w_rt_hit;

  assign w_dst_nonzero = (ex_rt_i != REG_AW'(REG_ZERO));
  assign w_rs_hit      = (ex_rt_i == id_rs_i);
  assign w_rt_hit      = id_uses_rt_i && (ex_rt_i == id_rt_i);
  assign load_use_o    = ex_memread_i && w_dst_nonzero && (w_rs_hit || w_rt_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and stall sequencer for the 5-stage MIPS pipeline. Optional performance
// counters are built when HAZARD_PERF_EN is defined.
module pipe_hazard_ctrl
  import pipe_hazard_pkg::*;
#(
  parameter int REG_AW       = 5,
  parameter int WAIT_TIMEOUT = 64,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] id_rs_i,
  input  logic [REG_AW-1:0] id_rt_i,
  input  logic              id_uses_rt_i,
  input  logic [REG_AW-1:0] ex_rt_i,
  input  logic              ex_memread_i,
  input  logic              branch_taken_i,
  input  logic              dmem_busy_i,
  output logic              pc_write_o,
  output logic              ifid_write_o,
  output logic              ifid_flush_o,
  output logic              idex_stall_o,
  output logic              idex_bubble_o,
  output logic              freeze_o,
  output logic              timeout_o,
  output logic [STATE_W-1:0] state_o
`ifdef HAZARD_PERF_EN
  ,
  output logic [CNT_W-1:0]  lu_stall_cnt_o,
  output logic [CNT_W-1:0]  mem_wait_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o
`endif
);

  localparam int WCNT_W = $clog2(WAIT_TIMEOUT + 1);

  hz_state_e         r_state;
  hz_state_e         w_state_nxt;
  hz_win_e           w_win;
  hz_ctrl_t          w_ctrl;
  logic              w_load_use;
  logic [WCNT_W-1:0] r_wait_cnt;
  logic              r_timeout;

  hazard_cmp #(.REG_AW(REG_AW)) u_hazard_cmp (
    .id_rs_i      (id_rs_i),
    .id_rt_i      (id_rt_i),
    .id_uses_rt_i (id_uses_rt_i),
    .ex_rt_i      (ex_rt_i),
    .ex_memread_i (ex_memread_i),
    .load_use_o   (w_load_use)
  );

  always_comb begin
    w_win = WIN_NORMAL;
    if (dmem_busy_i)         w_win = WIN_BUSY;
    else if (w_load_use)     w_win = WIN_LOAD_USE;
    else if (branch_taken_i) w_win = WIN_BRANCH;
  end

  always_comb begin
    w_state_nxt = ST_RUN;
    case (r_state)
      // Busy dropping always passes through RECOVER so a deferred load-use is re-seen.
      ST_MEM_WAIT: w_state_nxt = dmem_busy_i ? ST_MEM_WAIT : ST_RECOVER;
      ST_LU_STALL: w_state_nxt = dmem_busy_i ? ST_MEM_WAIT : ST_RUN;
      default: begin
        if (w_win == WIN_BUSY)          w_state_nxt = ST_MEM_WAIT;
        else if (w_win == WIN_LOAD_USE) w_state_nxt = ST_LU_STALL;
        else                            w_state_nxt = ST_RUN;
      end
    endcase
  end

  always_comb begin
    w_ctrl = CTRL_NORMAL;
    if (!rst_n) begin
      w_ctrl = CTRL_RESET;
    end else begin
      case (w_win)
        WIN_BUSY:     w_ctrl = CTRL_BUSY;
        WIN_LOAD_USE: w_ctrl = CTRL_LU;
        WIN_BRANCH:   w_ctrl = CTRL_BRANCH;
        default:      w_ctrl = CTRL_NORMAL;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_RUN;
      r_wait_cnt <= '0;
      r_timeout  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (dmem_busy_i) begin
        if (r_wait_cnt != WCNT_W'(WAIT_TIMEOUT)) r_wait_cnt <= r_wait_cnt + WCNT_W'(1);
        // Set on the edge where the count reaches the limit; sticky afterwards.
        if (r_wait_cnt >= WCNT_W'(WAIT_TIMEOUT - 1)) r_timeout <= 1'b1;
      end else begin
        r_wait_cnt <= '0;
      end
    end
  end

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] r_lu_cnt;
  logic [CNT_W-1:0] r_mw_cnt;
  logic [CNT_W-1:0] r_fl_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_lu_cnt <= '0;
      r_mw_cnt <= '0;
      r_fl_cnt <= '0;
    end else begin
      if (w_win == WIN_LOAD_USE && r_lu_cnt != '1) r_lu_cnt <= r_lu_cnt + CNT_W'(1);
      if (w_win == WIN_BUSY     && r_mw_cnt != '1) r_mw_cnt <= r_mw_cnt + CNT_W'(1);
      if (w_win == WIN_BRANCH   && r_fl_cnt != '1) r_fl_cnt <= r_fl_cnt + CNT_W'(1);
    end
  end

  assign lu_stall_cnt_o = r_lu_cnt;
  assign mem_wait_cnt_o = r_mw_cnt;
  assign flush_cnt_o    = r_fl_cnt;
`endif

  assign pc_write_o    = w_ctrl.pc_write;
  assign ifid_write_o  = w_ctrl.ifid_write;
  assign ifid_flush_o  = w_ctrl.ifid_flush;
  assign idex_stall_o  = w_ctrl.idex_stall;
  assign idex_bubble_o = w_ctrl.idex_bubble;
  assign freeze_o      = w_ctrl.freeze;
  assign timeout_o     = r_timeout;
  assign state_o       = r_state;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed testbench for pipe_hazard_ctrl: behavioural model checked every cycle plus
// hand-computed literal expectations for the listed scenarios.
module tb_pipe_hazard_ctrl;

  localparam int REG_AW       = 5;
  localparam int WAIT_TIMEOUT = 64;
  localparam int CNT_W        = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [REG_AW-1:0] id_rs_i, id_rt_i, ex_rt_i;
  logic              id_uses_rt_i, ex_memread_i, branch_taken_i, dmem_busy_i;
  logic              pc_write_o, ifid_write_o, ifid_flush_o;
  logic              idex_stall_o, idex_bubble_o, freeze_o, timeout_o;
  logic [1:0]        state_o;
`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0]  lu_stall_cnt_o, mem_wait_cnt_o, flush_cnt_o;
`endif

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.REG_AW(REG_AW), .WAIT_TIMEOUT(WAIT_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .id_rs_i        (id_rs_i),
    .id_rt_i        (id_rt_i),
    .id_uses_rt_i   (id_uses_rt_i),
    .ex_rt_i        (ex_rt_i),
    .ex_memread_i   (ex_memread_i),
    .branch_taken_i (branch_taken_i),
    .dmem_busy_i    (dmem_busy_i),
    .pc_write_o     (pc_write_o),
    .ifid_write_o   (ifid_write_o),
    .ifid_flush_o   (ifid_flush_o),
    .idex_stall_o   (idex_stall_o),
    .idex_bubble_o  (idex_bubble_o),
    .freeze_o       (freeze_o),
    .timeout_o      (timeout_o),
    .state_o        (state_o)
`ifdef HAZARD_PERF_EN
    ,
    .lu_stall_cnt_o (lu_stall_cnt_o),
    .mem_wait_cnt_o (mem_wait_cnt_o),
    .flush_cnt_o    (flush_cnt_o)
`endif
  );

  int n_assert = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_assert++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_state;
  int m_busy_run;
  bit m_timeout;
  int m_lu_cnt, m_mw_cnt, m_fl_cnt;

  function automatic bit f_load_use();
    return ex_memread_i && (ex_rt_i != 0) &&
           ((ex_rt_i == id_rs_i) || (id_uses_rt_i && (ex_rt_i == id_rt_i)));
  endfunction

  // 3 = busy, 2 = load-use, 1 = branch, 0 = normal
  function automatic int f_winner();
    if (dmem_busy_i)    return 3;
    if (f_load_use())   return 2;
    if (branch_taken_i) return 1;
    return 0;
  endfunction

  // bit order: pc_write, ifid_write, ifid_flush, idex_stall, idex_bubble, freeze
  function automatic int f_ctrl();
    if (!rst_n) return 'b001010;
    case (f_winner())
      3:       return 'b000101;
      2:       return 'b000010;
      1:       return 'b111000;
      default: return 'b110000;
    endcase
  endfunction

  function automatic int f_sat(input int v);
    return (v > (1 << CNT_W) - 1) ? (1 << CNT_W) - 1 : v;
  endfunction

  always @(posedge clk) begin : model
    int win;
    win = f_winner();
    if (!rst_n) begin
      m_state    <= 0;
      m_busy_run <= 0;
      m_timeout  <= 1'b0;
      m_lu_cnt   <= 0;
      m_mw_cnt   <= 0;
      m_fl_cnt   <= 0;
    end else begin
      if (m_state == 2 && !dmem_busy_i)      m_state <= 3;
      else if (dmem_busy_i)                  m_state <= 2;
      else if (win == 2 && m_state != 1)     m_state <= 1;
      else                                   m_state <= 0;
      m_busy_run <= dmem_busy_i ? m_busy_run + 1 : 0;
      if (dmem_busy_i && m_busy_run + 1 >= WAIT_TIMEOUT) m_timeout <= 1'b1;
      if (win == 2) m_lu_cnt <= m_lu_cnt + 1;
      if (win == 3) m_mw_cnt <= m_mw_cnt + 1;
      if (win == 1) m_fl_cnt <= m_fl_cnt + 1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("ctrl", int'({pc_write_o, ifid_write_o, ifid_flush_o,
                          idex_stall_o, idex_bubble_o, freeze_o}), f_ctrl());
      check("state", int'(state_o), m_state);
      check("timeout", int'(timeout_o), int'(m_timeout));
`ifdef HAZARD_PERF_EN
      check("lu_cnt", int'(lu_stall_cnt_o), f_sat(m_lu_cnt));
      check("mw_cnt", int'(mem_wait_cnt_o), f_sat(m_mw_cnt));
      check("fl_cnt", int'(flush_cnt_o), f_sat(m_fl_cnt));
`endif
    end
  end

  // ---------------- driver ----------------
  task automatic drive(input logic [REG_AW-1:0] rs, input logic [REG_AW-1:0] rt,
                       input bit uses_rt, input logic [REG_AW-1:0] ex_rt,
                       input bit memrd, input bit br, input bit busy);
    @(posedge clk);
    #1;
    id_rs_i        = rs;
    id_rt_i        = rt;
    id_uses_rt_i   = uses_rt;
    ex_rt_i        = ex_rt;
    ex_memread_i   = memrd;
    branch_taken_i = br;
    dmem_busy_i    = busy;
    @(negedge clk);
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    id_rs_i = '0; id_rt_i = '0; ex_rt_i = '0;
    id_uses_rt_i = 0; ex_memread_i = 0; branch_taken_i = 0; dmem_busy_i = 0;
    @(posedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    check("rst_pc_write", int'(pc_write_o), 0);
    check("rst_flush", int'(ifid_flush_o), 1);
    check("rst_bubble", int'(idex_bubble_o), 1);
    check("rst_state", int'(state_o), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("run_pc_write", int'(pc_write_o), 1);

    // lw $2 in EX, ID reads rs=$2: one stall cycle, then RUN
    drive(2, 7, 0, 2, 1, 0, 0);
    check("lu_pc_write", int'(pc_write_o), 0);
    check("lu_bubble", int'(idex_bubble_o), 1);
    drive(2, 7, 0, 9, 0, 0, 0);
    check("lu_state", int'(state_o), 1);
    check("lu_after_pc", int'(pc_write_o), 1);
    idle();
    check("lu_back_run", int'(state_o), 0);

    // $0 and non-read rt never stall; rt read does
    drive(0, 0, 0, 0, 1, 0, 0);
    check("zero_no_stall", int'(pc_write_o), 1);
    drive(5, 3, 0, 3, 1, 0, 0);
    check("rt_unused_no_stall", int'(pc_write_o), 1);
    drive(5, 3, 1, 3, 1, 0, 0);
    check("rt_used_stall", int'(idex_bubble_o), 1);
    idle();
    idle();

    // branch alone: one flush cycle, no stall
    drive(1, 1, 0, 0, 0, 1, 0);
    check("br_flush", int'(ifid_flush_o), 1);
    check("br_pc_write", int'(pc_write_o), 1);
    idle();
    check("br_flush_end", int'(ifid_flush_o), 0);

    // branch with load-use: stall wins, flush follows
    drive(4, 0, 0, 4, 1, 1, 0);
    check("br_lu_flush", int'(ifid_flush_o), 0);
    check("br_lu_bubble", int'(idex_bubble_o), 1);
    drive(4, 0, 0, 0, 0, 1, 0);
    check("br_lu_late_flush", int'(ifid_flush_o), 1);
    check("br_lu_state", int'(state_o), 1);
    idle();

    // 3 busy cycles with a load-use behind them
    for (int i = 0; i < 3; i++) begin
      drive(6, 0, 0, 6, 1, 0, 1);
      check("busy_freeze", int'(freeze_o), 1);
      check("busy_no_bubble", int'(idex_bubble_o), 0);
    end
    drive(6, 0, 0, 6, 1, 0, 0);
    check("busy_exit_state", int'(state_o), 2);
    check("busy_exit_freeze", int'(freeze_o), 0);
    drive(6, 0, 0, 6, 1, 0, 0);
    check("recover_state", int'(state_o), 3);
    check("recover_bubble", int'(idex_bubble_o), 1);
    drive(6, 0, 0, 0, 0, 0, 0);
    check("recover_lu_state", int'(state_o), 1);
    idle();
    check("recover_run", int'(state_o), 0);

    // long memory wait: timeout after WAIT_TIMEOUT busy edges, sticky
    for (int i = 1; i <= 70; i++) begin
      drive(0, 0, 0, 0, 0, 0, 1);
      check("timeout_rise", int'(timeout_o), (i > 64) ? 1 : 0);
    end
    idle();
    check("timeout_sticky", int'(timeout_o), 1);

    // reset in the middle of a freeze
    drive(0, 0, 0, 0, 0, 0, 1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_freeze", int'(freeze_o), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    dmem_busy_i = 1'b0;
    @(negedge clk);
    check("post_rst_timeout", int'(timeout_o), 0);
    check("post_rst_state", int'(state_o), 0);
    drive(0, 0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 1);
    idle();
    check("short_wait_no_timeout", int'(timeout_o), 0);
    idle();

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Hazard and stall sequencer for the 5-stage MIPS pipeline.
- Watches the ID-stage source registers, the ID/EX load destination, branch resolution and data-memory readiness.
- Drives PC write enable, IF/ID write/flush, the ID/EX hold (stall) and bubble controls, and a global freeze for EX/MEM and MEM/WB.
- Sits beside the decoder; ID/EX consumes idex_stall_o on its stall input.

Parameters:
- REG_AW, 5, register-address width.
- WAIT_TIMEOUT, 64, maximum consecutive dmem_busy_i cycles before timeout_o is raised.
- CNT_W, 16, width of the performance counters.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- id_rs_i  in  REG_AW  rs field of the instruction in ID.
- id_rt_i  in  REG_AW  rt field of the instruction in ID.
- id_uses_rt_i  in  1  the ID instruction reads rt (R-type, beq, sw).
- ex_rt_i  in  REG_AW  destination (rt) of the instruction in EX.
- ex_memread_i  in  1  the EX instruction is a load.
- branch_taken_i  in  1  branch or jump resolved taken in ID this cycle.
- dmem_busy_i  in  1  data memory is not ready; the pipeline must freeze.
- pc_write_o  out  1  PC update enable.
- ifid_write_o  out  1  IF/ID load enable.
- ifid_flush_o  out  1  zero the IF/ID instruction (nop).
- idex_stall_o  out  1  ID/EX holds its contents.
- idex_bubble_o  out  1  ID/EX loads zeroed control bits (RegWrite, MemWrite, MemRead, MemToReg = 0).
- freeze_o  out  1  hold EX/MEM and MEM/WB.
- timeout_o  out  1  sticky: the memory wait exceeded WAIT_TIMEOUT.
- state_o  out  2  current FSM state, for debug.

Behaviour:
- Reset and clocking
  - Only rst_n low at a rising clk edge resets: state := RUN, wait_cnt := 0, timeout_o := 0, counters := 0.
  - While rst_n is low, outputs are forced combinationally: pc_write_o=0, ifid_write_o=0, ifid_flush_o=1, idex_bubble_o=1, idex_stall_o=0, freeze_o=0.
- Hazard detection (combinational, zero latency)
  - load_use = ex_memread_i && ex_rt_i != 0 && (ex_rt_i == id_rs_i || (id_uses_rt_i && ex_rt_i == id_rt_i)).
  - Register 0 never causes a hazard.
- FSM states: RUN=0, LU_STALL=1, MEM_WAIT=2, RECOVER=3.
- Output priority, evaluated each cycle: dmem_busy_i > load_use > branch_taken_i > normal.
  - dmem_busy_i=1: freeze_o=1, idex_stall_o=1, pc_write_o=0, ifid_write_o=0, no flush, no bubble. Next state MEM_WAIT.
  - load_use, not busy: pc_write_o=0, ifid_write_o=0, idex_bubble_o=1, idex_stall_o=0. Next state LU_STALL.
  - A taken branch in the same cycle is ignored (no flush); it is re-resolved after the stall.
  - branch_taken_i only: ifid_flush_o=1, pc_write_o=1, ifid_write_o=1.
  - normal: pc_write_o=1, ifid_write_o=1, all other controls 0.
- LU_STALL
  - Lasts exactly one cycle; returns to RUN.
  - Re-evaluates hazards using the priority above. A second load_use is impossible because EX now holds a bubble.
- MEM_WAIT
  - Stays while dmem_busy_i=1; wait_cnt increments, saturating at WAIT_TIMEOUT.
  - When wait_cnt reaches WAIT_TIMEOUT, timeout_o := 1 (sticky until reset). The freeze continues.
  - When dmem_busy_i falls: go to RECOVER, wait_cnt := 0.
- RECOVER
  - One cycle of normal-priority evaluation, so a load_use deferred by the freeze is now honoured.
  - Next state: LU_STALL if load_use, MEM_WAIT if busy reasserts, else RUN.
- Frozen IF/ID, ID/EX and later registers keep their values exactly; no bubble or flush is applied while frozen.
- Reset mid-stall: returns to RUN on the next edge; any pending hazard is discarded.

Optional Feature:
- Macro: HAZARD_PERF_EN.
- Defined:
  - Adds outputs lu_stall_cnt_o, mem_wait_cnt_o, flush_cnt_o (CNT_W bits each).
  - Each counts the cycles in which its condition was the winning priority.
  - Counters saturate at all-ones and reset to 0.
- Undefined: these ports and their registers do not exist; all other behaviour is identical.

Decomposition:
- Package pipe_hazard_pkg:
  - state enum (RUN, LU_STALL, MEM_WAIT, RECOVER);
  - REG_ZERO constant;
  - control-bundle widths.
- One sub-module, hazard_cmp: the combinational load_use comparator (rs/rt/$0 check), reused later by the forwarding unit.

Test Plan:
- lw $2 in EX, ID reads rs=$2 → one cycle with pc_write_o=0, ifid_write_o=0, idex_bubble_o=1; then RUN with pc_write_o=1.
- lw $0 in EX, ID reads rs=$0 → no stall. lw $3, ID addi using rt=$3 with id_uses_rt_i=0 → no stall.
- branch_taken_i=1 alone → ifid_flush_o=1 for exactly one cycle, no stall.
- branch_taken_i and load_use in the same cycle → stall only, ifid_flush_o=0; branch held 1 next cycle → flush then.
- dmem_busy_i high for 3 cycles with load_use present → freeze_o=1 for 3 cycles, state 2→3, then LU_STALL for one cycle, then RUN.
- dmem_busy_i high for 70 cycles with WAIT_TIMEOUT=64 → timeout_o rises on cycle 64 and stays 1; rst_n low for one edge → timeout_o=0, state_o=0.
